dcache_axi_bridge: RTL and testbench

- Memory-side stage directly downstream of the data-cache controller.
- Converts the controller's per-word request/handshake stream (`mem_req`, `mem_addr_ok`, `mem_data_ok`, write-last) into AXI3/4 burst transactions: line refill (INCR read burst), line writeback (INCR write burst) and single-beat uncached accesses.
- One outstanding transaction at a time; the bridge owns all AXI valid/ready sequencing.

---
 rtl/dcache_axi_pkg.sv | 39 +++
 rtl/dcache_axi_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_dcache_axi_bridge.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_axi_pkg.sv
// Shared types and AXI constants for the data-cache to AXI bridge.
package dcache_axi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_WR_RESP
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [2:0] SIZE_WORD  = 3'b010;

   // Byte-lane strobe for a single uncached beat of the given size and address.
   function automatic logic [3:0] axi_wstrb_gen(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] strb;
      case (size)
         2'd0:    strb = 4'b0001 << addr_lo;
         2'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

   // AXI AxSIZE for an uncached beat; the cache encodes word as either 2 or 3.
   function automatic logic [2:0] axi_size_gen(input logic [1:0] size);
      logic [2:0] asize;
      if (size == 2'd3) begin
         asize = SIZE_WORD;
      end else begin
         asize = {1'b0, size};
      end
      return asize;
   endfunction

endpackage

// File: rtl/dcache_axi_bridge.sv
// Converts the data-cache per-word request stream into single-outstanding AXI
// bursts: INCR line refill, INCR line writeback and single-beat uncached access.
module dcache_axi_bridge
   import dcache_axi_pkg::*;
#(
   parameter int         LINE_WORDS = 8,
   parameter logic [3:0] AXI_ID     = 4'd1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic        mem_uncached,
   input  logic [31:0] mem_addr,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_wdata,
   output logic        mem_addr_ok,
   output logic        mem_data_ok,
   output logic [31:0] mem_rdata,
   output logic        mem_err,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   localparam logic [3:0] BURST_LEN = 4'(LINE_WORDS - 1);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        uncached_q, uncached_d;
   logic        err_q, err_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        arvalid_q, arvalid_d;
   logic        awvalid_q, awvalid_d;
   logic        addr_ok_q, addr_ok_d;

   logic [3:0]  len_w;
   logic [2:0]  size_w;
   logic [3:0]  strb_w;
   logic [3:0]  cnt_inc;
   logic        rready_c;
   logic        bready_c;
   logic        wvalid_c;
   logic        data_ok_c;
   logic        err_c;
   logic        unused_rid;

   // Burst shape is derived from the latched request, so it stays stable for the whole transaction.
   assign len_w   = uncached_q ? 4'd0 : BURST_LEN;
   assign size_w  = uncached_q ? axi_size_gen(size_q) : SIZE_WORD;
   assign strb_w  = uncached_q ? axi_wstrb_gen(size_q, addr_q[1:0]) : 4'b1111;
   assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

   // Next-state and handshake logic; the cache side sees combinational data_ok/err pulses.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      uncached_d = uncached_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      arvalid_d  = arvalid_q;
      awvalid_d  = awvalid_q;
      addr_ok_d  = 1'b0;
      rready_c   = 1'b0;
      bready_c   = 1'b0;
      wvalid_c   = 1'b0;
      data_ok_c  = 1'b0;
      err_c      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_req) begin
               addr_d     = mem_addr;
               size_d     = mem_size;
               uncached_d = mem_uncached;
               err_d      = 1'b0;
               if (mem_we) begin
                  awvalid_d = 1'b1;
                  state_d   = ST_WR_ADDR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_ADDR;
               end
            end
         end
         ST_RD_ADDR: begin
            if (arvalid_q && arready) begin
               arvalid_d = 1'b0;
               addr_ok_d = 1'b1;
               cnt_d     = 4'd0;
               state_d   = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            rready_c = 1'b1;
            if (rvalid) begin
               data_ok_c = 1'b1;
               cnt_d     = cnt_inc;
               if (rresp != RESP_OKAY) begin
                  err_d = 1'b1;
               end
               if (rlast) begin
                  err_c   = err_q | (rresp != RESP_OKAY);
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WR_ADDR: begin
            if (awvalid_q && awready) begin
               awvalid_d = 1'b0;
               addr_ok_d = 1'b1;
               cnt_d     = 4'd0;
               state_d   = ST_WR_DATA;
            end
         end
         ST_WR_DATA: begin
            wvalid_c = mem_req & mem_we;
            if (wvalid_c && wready) begin
               data_ok_c = 1'b1;
               cnt_d     = cnt_inc;
               if (cnt_q == len_w) begin
                  state_d = ST_WR_RESP;
               end
            end
         end
         ST_WR_RESP: begin
            bready_c = 1'b1;
            if (bvalid) begin
               err_c   = err_q | (bresp != RESP_OKAY);
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched request registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         addr_q     <= 32'd0;
         size_q     <= 2'd0;
         uncached_q <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= 4'd0;
         arvalid_q  <= 1'b0;
         awvalid_q  <= 1'b0;
         addr_ok_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         uncached_q <= uncached_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         arvalid_q  <= arvalid_d;
         awvalid_q  <= awvalid_d;
         addr_ok_q  <= addr_ok_d;
      end
   end

   // Only one transaction is ever outstanding, so the returned read ID carries no information.
   assign unused_rid = ^rid;

   assign arid        = AXI_ID;
   assign araddr      = addr_q;
   assign arlen       = len_w;
   assign arsize      = size_w;
   assign arburst     = BURST_INCR;
   assign arvalid     = arvalid_q;
   assign rready      = rready_c;

   assign awid        = AXI_ID;
   assign awaddr      = addr_q;
   assign awlen       = len_w;
   assign awsize      = size_w;
   assign awburst     = BURST_INCR;
   assign awvalid     = awvalid_q;

   assign wdata       = mem_wdata;
   assign wstrb       = strb_w;
   assign wlast       = (state_q == ST_WR_DATA) && (cnt_q == len_w);
   assign wvalid      = wvalid_c;
   assign bready      = bready_c;

   assign mem_addr_ok = addr_ok_q;
   assign mem_data_ok = data_ok_c;
   assign mem_rdata   = rdata;
   assign mem_err     = err_c;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Self-checking bench for dcache_axi_bridge: the bench plays both the cache
// controller and the AXI slave, with expectations from a transaction-level model.
module tb_dcache_axi_bridge;

   localparam int          LINE_WORDS = 8;
   localparam logic [31:0] LINE_MASK  = ~32'(LINE_WORDS * 4 - 1);

   logic        clk;
   logic        resetn;
   logic        mem_req;
   logic        mem_we;
   logic        mem_uncached;
   logic [31:0] mem_addr;
   logic [1:0]  mem_size;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int          checks;
   int          failures;
   logic [3:0]  cap_len;
   logic [2:0]  cap_size;
   logic [3:0]  cap_strb;

   typedef struct {
      bit          we;
      bit          unc;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  exp_len;
      logic [2:0]  exp_size;
      logic [3:0]  exp_strb;
   } vec_t;

   vec_t        vecs [10];
   logic        r_we;
   logic        r_unc;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   int          r_n;
   int          r_eb;

   dcache_axi_bridge #(.LINE_WORDS(LINE_WORDS), .AXI_ID(4'd1)) dut (
      .clk(clk), .resetn(resetn),
      .mem_req(mem_req), .mem_we(mem_we), .mem_uncached(mem_uncached),
      .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata), .mem_err(mem_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a handshake never completes.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Reference model: bytes per beat, AXI size, burst length and strobe from the access rules.
   function automatic int ref_bytes(input logic unc, input logic [1:0] size);
      if (!unc || size >= 2'd2) return 4;
      return 1 << size;
   endfunction

   function automatic logic [31:0] ref_size(input logic unc, input logic [1:0] size);
      return 32'($clog2(ref_bytes(unc, size)));
   endfunction

   function automatic logic [31:0] ref_len(input logic unc);
      return unc ? 32'd0 : 32'(LINE_WORDS - 1);
   endfunction

   function automatic logic [3:0] ref_strb(input logic unc, input logic [1:0] size, input logic [31:0] addr);
      int nb;
      int lane;
      nb   = ref_bytes(unc, size);
      lane = (int'(addr[1:0]) / nb) * nb;
      return 4'(((1 << nb) - 1) << lane);
   endfunction

   function automatic logic [7:0] ctrl_vec();
      return {arvalid, rready, awvalid, wvalid, bready, mem_addr_ok, mem_data_ok, mem_err};
   endfunction

   // One comparison, counted and reported on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      mem_req = 1'b0; mem_we = 1'b0; mem_uncached = 1'b0;
      mem_addr = 32'd0; mem_size = 2'd0; mem_wdata = 32'd0;
      arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = 2'd0; bvalid = 1'b0;
   endtask

   // One idle cycle with all inputs quiet: every handshake output must be low.
   task automatic settleIdle(input string name);
      @(posedge clk); #1;
      clearInputs();
      #1;
      checkOutput(name, 32'(ctrl_vec()), 32'd0);
   endtask

   // Read transaction: cache requests, slave answers with optional gaps and an error beat.
   task automatic runRead(input logic [31:0] addr, input logic unc, input logic [1:0] size,
                          input logic [31:0] data_base, input bit rnd_data, input int err_beat,
                          input int ar_delay, input bit gaps, input int lag, input int abort_after);
      int          n, beat, wait_cnt, cyc, ok_cnt;
      bit          ar_seen, ar_hs_prev, pending, err_acc;
      bit          e_arv, e_rr, e_aok, e_dok, e_err;
      logic [31:0] words [16];
      n = unc ? 1 : LINE_WORDS;
      for (int i = 0; i < 16; i++) words[i] = rnd_data ? $urandom : data_base + 32'(i);
      beat = 0; wait_cnt = ar_delay; cyc = 0; ok_cnt = 0;
      ar_seen = 0; ar_hs_prev = 0; pending = 0; err_acc = 0;
      mem_req = 1'b1; mem_we = 1'b0; mem_uncached = unc; mem_addr = addr; mem_size = size;
      while (beat < n && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
         e_arv   = (cyc > lag) && !ar_seen;
         arready = e_arv && (wait_cnt == 0);
         if (e_arv && wait_cnt > 0) wait_cnt--;
         rvalid = pending || (ar_seen && (!gaps || $urandom_range(0, 2) != 0));
         rdata  = words[beat];
         rlast  = (beat == n - 1);
         rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
         rid    = 4'($urandom_range(0, 15));
         #1;
         e_rr  = ar_seen;
         e_aok = ar_hs_prev;
         e_dok = rvalid && e_rr;
         e_err = e_dok && rlast && (err_acc || rresp != 2'b00);
         checkOutput("rd_ctrl", 32'(ctrl_vec()), 32'({e_arv, e_rr, 3'b000, e_aok, e_dok, e_err}));
         if (mem_data_ok) ok_cnt++;
         ar_hs_prev = 0;
         if (e_arv && arready) begin
            checkOutput("araddr", araddr, addr);
            checkOutput("arburst", 32'(arburst), 32'h1);
            checkOutput("arid", 32'(arid), 32'h1);
            cap_len = arlen; cap_size = arsize;
            ar_seen = 1; ar_hs_prev = 1;
         end
         if (e_aok) mem_req = 1'b0;
         if (e_dok) begin
            checkOutput("rdata", mem_rdata, words[beat]);
            err_acc = err_acc || (rresp != 2'b00);
            beat++;
            pending = 0;
            if (abort_after > 0 && beat == abort_after) return;
         end else begin
            pending = rvalid;
         end
      end
      checkOutput("rd_done", 32'(beat), 32'(n));
      checkOutput("rd_beats", 32'(ok_cnt), 32'(n));
   endtask

   // Write transaction: cache streams words, slave throttles W and returns a B response.
   task automatic runWrite(input logic [31:0] addr, input logic unc, input logic [1:0] size,
                           input logic [31:0] data_base, input bit rnd_data, input int aw_delay,
                           input int wmode, input logic [1:0] bresp_val, input int b_delay, input int lag);
      int          n, beat, wait_cnt, bwait, cyc, ok_cnt;
      bit          aw_seen, aw_hs_prev, w_done, b_done;
      bit          e_awv, e_wv, e_br, e_aok, e_dok, e_err;
      logic [3:0]  exp_strb;
      logic [31:0] words [16];
      n = unc ? 1 : LINE_WORDS;
      for (int i = 0; i < 16; i++) words[i] = rnd_data ? $urandom : data_base + 32'(i);
      exp_strb = ref_strb(unc, size, addr);
      beat = 0; wait_cnt = aw_delay; bwait = b_delay; cyc = 0; ok_cnt = 0;
      aw_seen = 0; aw_hs_prev = 0; w_done = 0; b_done = 0;
      mem_req = 1'b1; mem_we = 1'b1; mem_uncached = unc; mem_addr = addr; mem_size = size;
      mem_wdata = words[0];
      while (!b_done && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
         e_awv   = (cyc > lag) && !aw_seen;
         awready = e_awv && (wait_cnt == 0);
         if (e_awv && wait_cnt > 0) wait_cnt--;
         e_wv = aw_seen && !w_done;
         case (wmode)
            0:       wready = 1'b1;
            1:       wready = (cyc % 2 == 0);
            default: wready = 1'($urandom_range(0, 1));
         endcase
         mem_wdata = words[beat];
         mem_req   = !w_done;
         e_br   = w_done;
         bvalid = e_br && (bwait == 0);
         if (e_br && bwait > 0) bwait--;
         bresp = bresp_val;
         #1;
         e_aok = aw_hs_prev;
         e_dok = e_wv && wready;
         e_err = e_br && bvalid && (bresp_val != 2'b00);
         checkOutput("wr_ctrl", 32'(ctrl_vec()), 32'({2'b00, e_awv, e_wv, e_br, e_aok, e_dok, e_err}));
         if (mem_data_ok) ok_cnt++;
         aw_hs_prev = 0;
         if (e_awv && awready) begin
            checkOutput("awaddr", awaddr, addr);
            checkOutput("awburst", 32'(awburst), 32'h1);
            checkOutput("awid", 32'(awid), 32'h1);
            cap_len = awlen; cap_size = awsize;
            aw_seen = 1; aw_hs_prev = 1;
         end
         if (e_dok) begin
            checkOutput("wdata", wdata, words[beat]);
            checkOutput("wstrb", 32'(wstrb), 32'(exp_strb));
            checkOutput("wlast", 32'(wlast), 32'(beat == n - 1));
            cap_strb = wstrb;
            beat++;
            if (beat == n) w_done = 1;
         end
         if (e_br && bvalid) b_done = 1;
      end
      checkOutput("wr_done", 32'(b_done), 32'd1);
      checkOutput("wr_beats", 32'(ok_cnt), 32'(n));
   endtask

   // Table entry: run the access, then compare the AXI burst shape with the tabulated values.
   task automatic applyStimulus(input vec_t v);
      if (v.we) begin
         runWrite(v.addr, v.unc, v.size, 32'h5A5A_5A5A, 1'b0, 1, 0, 2'b00, 1, 0);
      end else begin
         runRead(v.addr, v.unc, v.size, 32'h0000_00C0, 1'b0, -1, 1, 1'b0, 0, 0);
      end
      settleIdle("tbl_idle");
      checkOutput("tbl_len", 32'(cap_len), 32'(v.exp_len));
      checkOutput("tbl_size", 32'(cap_size), 32'(v.exp_size));
      if (v.we) checkOutput("tbl_strb", 32'(cap_strb), 32'(v.exp_strb));
   endtask

   // Main sequence: reset, table, directed corner cases, then randomized traffic.
   initial begin
      checks = 0;
      failures = 0;
      vecs[0] = '{0, 0, 32'h1000_0020, 2'd2, 4'd7, 3'd2, 4'hF};
      vecs[1] = '{1, 0, 32'h2000_0040, 2'd2, 4'd7, 3'd2, 4'hF};
      vecs[2] = '{1, 1, 32'h1FAF_0003, 2'd0, 4'd0, 3'd0, 4'b1000};
      vecs[3] = '{1, 1, 32'h1FAF_0001, 2'd0, 4'd0, 3'd0, 4'b0010};
      vecs[4] = '{1, 1, 32'h0000_0002, 2'd1, 4'd0, 3'd1, 4'b1100};
      vecs[5] = '{1, 1, 32'h0000_0000, 2'd1, 4'd0, 3'd1, 4'b0011};
      vecs[6] = '{1, 1, 32'h0000_0004, 2'd3, 4'd0, 3'd2, 4'hF};
      vecs[7] = '{0, 1, 32'h3000_0006, 2'd1, 4'd0, 3'd1, 4'hF};
      vecs[8] = '{0, 1, 32'h3000_0008, 2'd3, 4'd0, 3'd2, 4'hF};
      vecs[9] = '{1, 1, 32'h4000_0008, 2'd2, 4'd0, 3'd2, 4'hF};

      clearInputs();
      resetn = 1'b1;
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("reset_ctrl", 32'(ctrl_vec()), 32'd0);
      checkOutput("reset_araddr", araddr, 32'd0);
      checkOutput("reset_awaddr", awaddr, 32'd0);
      repeat (3) @(posedge clk);
      #2 resetn = 1'b1;
      settleIdle("post_reset_idle");

      for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

      $display("[TB] cached refill with gaps");
      runRead(32'h1000_0020, 1'b0, 2'd2, 32'h0000_00A0, 1'b0, -1, 2, 1'b1, 0, 0);
      settleIdle("refill_idle");
      checkOutput("refill_len", 32'(cap_len), 32'd7);

      $display("[TB] writeback with toggling wready");
      runWrite(32'h2000_0100, 1'b0, 2'd2, 32'h0000_00B0, 1'b0, 0, 1, 2'b00, 2, 0);
      settleIdle("wb_idle");
      checkOutput("wb_len", 32'(cap_len), 32'd7);

      $display("[TB] refill with error on third beat");
      runRead(32'h1000_0040, 1'b0, 2'd2, 32'h0000_0D00, 1'b0, 2, 0, 1'b1, 0, 0);
      settleIdle("err_idle");

      $display("[TB] reset in the middle of a refill");
      runRead(32'h1000_0060, 1'b0, 2'd2, 32'h0000_0E00, 1'b0, -1, 0, 1'b0, 0, 3);
      #1 resetn = 1'b0;
      #1;
      checkOutput("midrst_ctrl", 32'(ctrl_vec()), 32'd0);
      checkOutput("midrst_araddr", araddr, 32'd0);
      clearInputs();
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;
      settleIdle("midrst_idle");
      runRead(32'h1000_0080, 1'b0, 2'd2, 32'h0000_0F00, 1'b0, -1, 1, 1'b1, 0, 0);
      settleIdle("midrst_recover_idle");

      $display("[TB] writeback followed back-to-back by refill");
      runWrite(32'h2000_0200, 1'b0, 2'd2, 32'h0000_1100, 1'b0, 1, 2, 2'b00, 1, 0);
      runRead(32'h1000_00A0, 1'b0, 2'd2, 32'h0000_1200, 1'b0, -1, 1, 1'b1, 1, 0);
      settleIdle("b2b_idle");

      $display("[TB] randomized traffic");
      for (int t = 0; t < 30; t++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_unc  = 1'($urandom_range(0, 1));
         r_size = 2'($urandom_range(0, 3));
         r_addr = $urandom;
         if (!r_unc) r_addr = r_addr & LINE_MASK;
         r_n  = r_unc ? 1 : LINE_WORDS;
         r_eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, r_n - 1)) : -1;
         if (r_we) begin
            runWrite(r_addr, r_unc, r_size, 32'd0, 1'b1, int'($urandom_range(0, 3)), 2,
                     ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00, int'($urandom_range(0, 3)), 0);
         end else begin
            runRead(r_addr, r_unc, r_size, 32'd0, 1'b1, r_eb, int'($urandom_range(0, 3)), 1'b1, 0, 0);
         end
         settleIdle("rnd_idle");
         checkOutput("rnd_len", 32'(cap_len), ref_len(r_unc));
         checkOutput("rnd_size", 32'(cap_size), ref_size(r_unc, r_size));
         if (r_we) checkOutput("rnd_strb", 32'(cap_strb), 32'(ref_strb(r_unc, r_size, r_addr)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
